mac_iter_ctrl: RTL and testbench

MAC_ITER_CTRL -- requirements
Module: mac_iter_ctrl

---
 rtl/mac_iter_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mac_iter_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_iter_ctrl.sv
// Iteration controller for a MAC engine and its streamers: sequences nb_iter scalar products.
// Optional COMPUTE/WAIT watchdog enabled by defining MAC_ITER_CTRL_WATCHDOG_EN.
module mac_iter_ctrl #(
    parameter int unsigned CNT_LEN   = 1024,
    parameter int unsigned NB_ITER_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [NB_ITER_W-1:0]       nb_iter_i,
    input  logic [$clog2(CNT_LEN):0]   len_i,
    input  logic [4:0]                 shift_i,
    input  logic                       simple_mul_i,
    input  logic                       eng_acc_done_i,
    input  logic                       strm_ready_i,
    input  logic                       strm_done_i,
    output logic                       eng_clear_o,
    output logic                       eng_enable_o,
    output logic                       eng_start_o,
    output logic                       eng_simple_mul_o,
    output logic [4:0]                 eng_shift_o,
    output logic [$clog2(CNT_LEN):0]   eng_len_o,
    output logic                       strm_req_o,
    output logic [NB_ITER_W-1:0]       iter_idx_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       error_o
);

    localparam int unsigned LEN_W = $clog2(CNT_LEN) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_COMPUTE,
        S_WAIT,
        S_UPDATEIDX,
        S_TERMINATE
    } state_e;

    state_e               state_q, state_d;
    logic [NB_ITER_W-1:0] nb_iter_q, nb_iter_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [4:0]           shift_q, shift_d;
    logic                 smul_q, smul_d;
    logic [NB_ITER_W-1:0] idx_q, idx_d;
    logic                 start_q, start_d;
    logic                 clear_q, clear_d;
    logic                 enable_q, enable_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

`ifdef MAC_ITER_CTRL_WATCHDOG_EN
    localparam int unsigned WD_W = LEN_W + 7;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [WD_W-1:0] wd_last;
    logic            err_q, err_d;

    // Last permitted count before the timeout fires: 4*len + 64 cycles in total.
    assign wd_last = (WD_W'(len_q) << 2) + WD_W'(63);
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        nb_iter_d = nb_iter_q;
        len_d     = len_q;
        shift_d   = shift_q;
        smul_d    = smul_q;
        idx_d     = idx_q;
        start_d   = 1'b0;
`ifdef MAC_ITER_CTRL_WATCHDOG_EN
        wd_cnt_d  = wd_cnt_q;
        err_d     = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
`ifdef MAC_ITER_CTRL_WATCHDOG_EN
                    err_d = 1'b0;
`endif
                    if (nb_iter_i != '0) begin
                        nb_iter_d = nb_iter_i;
                        len_d     = len_i;
                        shift_d   = shift_i;
                        smul_d    = simple_mul_i;
                        idx_d     = '0;
                        state_d   = S_START;
                    end else begin
                        state_d   = S_TERMINATE;
                    end
                end
            end
            S_START: begin
                if (strm_ready_i) begin
                    start_d = 1'b1;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (eng_acc_done_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (strm_done_i) begin
                    state_d = S_UPDATEIDX;
                end
            end
            S_UPDATEIDX: begin
                if (idx_q == nb_iter_q - NB_ITER_W'(1)) begin
                    state_d = S_TERMINATE;
                end else begin
                    idx_d   = idx_q + NB_ITER_W'(1);
                    state_d = S_START;
                end
            end
            S_TERMINATE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MAC_ITER_CTRL_WATCHDOG_EN
        // Timeout overrides normal progress out of COMPUTE/WAIT.
        if (state_q == S_COMPUTE || state_q == S_WAIT) begin
            if (wd_cnt_q == wd_last) begin
                err_d   = 1'b1;
                state_d = S_TERMINATE;
            end else begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
        end
        if (state_d == S_START) begin
            wd_cnt_d = '0;
        end
`endif

        clear_d  = (state_d == S_START);
        enable_d = (state_d == S_COMPUTE);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_TERMINATE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            nb_iter_q <= '0;
            len_q     <= '0;
            shift_q   <= '0;
            smul_q    <= 1'b0;
            idx_q     <= '0;
            start_q   <= 1'b0;
            clear_q   <= 1'b0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MAC_ITER_CTRL_WATCHDOG_EN
            wd_cnt_q  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            nb_iter_q <= nb_iter_d;
            len_q     <= len_d;
            shift_q   <= shift_d;
            smul_q    <= smul_d;
            idx_q     <= idx_d;
            start_q   <= start_d;
            clear_q   <= clear_d;
            enable_q  <= enable_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MAC_ITER_CTRL_WATCHDOG_EN
            wd_cnt_q  <= wd_cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign eng_clear_o      = clear_q;
    assign eng_enable_o     = enable_q;
    assign eng_start_o      = start_q;
    assign strm_req_o       = start_q;
    assign eng_simple_mul_o = smul_q;
    assign eng_shift_o      = shift_q;
    assign eng_len_o        = len_q;
    assign iter_idx_o       = idx_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
`ifdef MAC_ITER_CTRL_WATCHDOG_EN
    assign error_o          = err_q;
`else
    assign error_o          = 1'b0;
`endif

endmodule

// File: tb/tb_mac_iter_ctrl.sv
// Randomized bench for mac_iter_ctrl: jobs are expanded into per-cycle input and expected-output traces.
module tb_mac_iter_ctrl;

    localparam int unsigned LW = 11;
    localparam int unsigned NW = 16;

    logic          clk = 1'b0;
    logic          rst_n, start, smul, acc_done, s_ready, s_done;
    logic [NW-1:0] nb_iter;
    logic [LW-1:0] len;
    logic [4:0]    shift;
    logic          eng_clear_o, eng_enable_o, eng_start_o, eng_simple_mul_o, strm_req_o;
    logic [4:0]    eng_shift_o;
    logic [LW-1:0] eng_len_o;
    logic [NW-1:0] iter_idx_o;
    logic          busy_o, done_o, error_o;

    always #5 clk = ~clk;

    mac_iter_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .nb_iter_i(nb_iter), .len_i(len),
        .shift_i(shift), .simple_mul_i(smul), .eng_acc_done_i(acc_done),
        .strm_ready_i(s_ready), .strm_done_i(s_done),
        .eng_clear_o(eng_clear_o), .eng_enable_o(eng_enable_o), .eng_start_o(eng_start_o),
        .eng_simple_mul_o(eng_simple_mul_o), .eng_shift_o(eng_shift_o), .eng_len_o(eng_len_o),
        .strm_req_o(strm_req_o), .iter_idx_o(iter_idx_o), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o)
    );

    typedef struct packed {
        logic rst_n, start;
        logic [NW-1:0] nb;
        logic [LW-1:0] len;
        logic [4:0] shift;
        logic smul, acc, rdy, sdone;
    } in_t;

    typedef struct packed {
        logic clear, enable, estart, req, smul;
        logic [4:0] shift;
        logic [LW-1:0] len;
        logic [NW-1:0] idx;
        logic busy, done, err;
    } out_t;

    typedef struct {
        int cyc;
        int es;
        int dn;
        int ln;
    } mark_t;

    typedef enum int {P_IDLE, P_START, P_COMP, P_WAIT, P_UPD, P_TERM} ph_e;

    in_t   in_q[$];
    out_t  exp_q[$];
    mark_t mk_q[$];

    // Architectural view of the job as seen from the outputs.
    logic [LW-1:0] m_len;
    logic [4:0]    m_shift;
    logic          m_smul;
    logic [NW-1:0] m_idx;
    logic          m_err;

    int n_vec = 0;
    int n_mis = 0;
    int cnt_es = 0;
    int cnt_dn = 0;

    function automatic in_t noise();
        in_t n;
        n.rst_n = 1'b1;
        n.start = 1'($urandom_range(1, 0));
        n.nb    = NW'($urandom);
        n.len   = LW'($urandom);
        n.shift = 5'($urandom);
        n.smul  = 1'($urandom_range(1, 0));
        n.acc   = 1'($urandom_range(1, 0));
        n.rdy   = 1'($urandom_range(1, 0));
        n.sdone = 1'($urandom_range(1, 0));
        return n;
    endfunction

    function automatic out_t mk(ph_e ph, bit es);
        out_t o;
        o.clear  = (ph == P_START);
        o.enable = (ph == P_COMP);
        o.estart = es;
        o.req    = es;
        o.smul   = m_smul;
        o.shift  = m_shift;
        o.len    = m_len;
        o.idx    = m_idx;
        o.busy   = (ph != P_IDLE);
        o.done   = (ph == P_TERM);
        o.err    = m_err;
        return o;
    endfunction

    task automatic push(input in_t i, input out_t o);
        in_q.push_back(i);
        exp_q.push_back(o);
    endtask

    task automatic zero_model();
        m_len = '0; m_shift = '0; m_smul = 1'b0; m_idx = '0; m_err = 1'b0;
    endtask

    task automatic idle(input int n);
        in_t i;
        repeat (n) begin
            i = noise();
            i.start = 1'b0;
            push(i, mk(P_IDLE, 1'b0));
        end
    endtask

    task automatic rst(input int n);
        in_t i;
        zero_model();
        repeat (n) begin
            i = noise();
            i.rst_n = 1'b0;
            push(i, mk(P_IDLE, 1'b0));
        end
    endtask

    task automatic mark(input int es, input int dn, input int ln);
        mark_t m;
        m.cyc = in_q.size(); m.es = es; m.dn = dn; m.ln = ln;
        mk_q.push_back(m);
    endtask

    // Expand one job: per iteration, ready/acc/strm-done delays drawn from the given ranges.
    task automatic job(input int nb, input int ln, input int rmin, input int rmax,
                       input int amin, input int amax, input int dmin, input int dmax,
                       input int abort_k, input bit hang);
        in_t n;
        int  r, a, d;
        n = noise();
        n.start = 1'b1;
        n.nb    = NW'(nb);
        n.len   = LW'(ln);
        m_err   = 1'b0;
        if (nb == 0) begin
            push(n, mk(P_TERM, 1'b0));
            push(noise(), mk(P_IDLE, 1'b0));
            return;
        end
        m_len = n.len; m_shift = n.shift; m_smul = n.smul; m_idx = '0;
        push(n, mk(P_START, 1'b0));
        for (int k = 0; k < nb; k++) begin
            r = int'($urandom_range(rmax, rmin));
            a = int'($urandom_range(amax, amin));
            d = int'($urandom_range(dmax, dmin));
            repeat (r) begin n = noise(); n.rdy = 1'b0; push(n, mk(P_START, 1'b0)); end
            n = noise(); n.rdy = 1'b1; push(n, mk(P_COMP, 1'b1));
            if (hang) begin
                repeat (95) begin n = noise(); n.acc = 1'b0; push(n, mk(P_COMP, 1'b0)); end
                m_err = 1'b1;
                n = noise(); n.acc = 1'b0; push(n, mk(P_TERM, 1'b0));
                push(noise(), mk(P_IDLE, 1'b0));
                return;
            end
            repeat (a) begin n = noise(); n.acc = 1'b0; push(n, mk(P_COMP, 1'b0)); end
            n = noise(); n.acc = 1'b1; push(n, mk(P_WAIT, 1'b0));
            if (k == abort_k) begin
                rst(1);
                return;
            end
            repeat (d) begin n = noise(); n.sdone = 1'b0; push(n, mk(P_WAIT, 1'b0)); end
            n = noise(); n.sdone = 1'b1; push(n, mk(P_UPD, 1'b0));
            if (k == nb - 1) begin
                push(noise(), mk(P_TERM, 1'b0));
            end else begin
                m_idx = NW'(k + 1);
                push(noise(), mk(P_START, 1'b0));
            end
        end
        push(noise(), mk(P_IDLE, 1'b0));
    endtask

    task automatic drive(input in_t i);
        rst_n = i.rst_n; start = i.start; nb_iter = i.nb; len = i.len; shift = i.shift;
        smul = i.smul; acc_done = i.acc; s_ready = i.rdy; s_done = i.sdone;
    endtask

    initial begin
        out_t act;
        int   mi;
        zero_model();

        rst(2);
        idle(2);
        job(3, 8, 0, 0, 7, 7, 1, 1, -1, 1'b0);
        mark(3, 1, 8);
        idle(1);
        job(0, 8, 0, 0, 0, 0, 0, 0, -1, 1'b0);
        mark(3, 2, -1);
        job(1, 8, 5, 5, 3, 3, 0, 0, -1, 1'b0);
        mark(4, 3, 8);
        job(3, 8, 0, 2, 0, 4, 0, 3, 1, 1'b0);
        mark(6, 3, 0);
        idle(2);
        for (int j = 0; j < 40; j++) begin
            idle(int'($urandom_range(3, 0)));
            if ($urandom_range(9, 0) == 0) rst(1);
            job(int'($urandom_range(4, 0)), int'($urandom_range(1024, 0)),
                0, int'($urandom_range(6, 0)), 0, int'($urandom_range(20, 0)),
                0, int'($urandom_range(10, 0)),
                ($urandom_range(7, 0) == 0) ? int'($urandom_range(2, 0)) : -1, 1'b0);
        end
`ifdef MAC_ITER_CTRL_WATCHDOG_EN
        idle(2);
        job(1, 8, 0, 0, 0, 0, 0, 0, -1, 1'b1);
        idle(3);
        job(2, 8, 0, 2, 0, 5, 0, 5, -1, 1'b0);
`endif
        idle(3);

        mi = 0;
        for (int t = 0; t < in_q.size(); t++) begin
            drive(in_q[t]);
            @(posedge clk);
            #1;
            act.clear  = eng_clear_o;
            act.enable = eng_enable_o;
            act.estart = eng_start_o;
            act.req    = strm_req_o;
            act.smul   = eng_simple_mul_o;
            act.shift  = eng_shift_o;
            act.len    = eng_len_o;
            act.idx    = iter_idx_o;
            act.busy   = busy_o;
            act.done   = done_o;
            act.err    = error_o;
            n_vec++;
            if (act !== exp_q[t]) begin
                n_mis++;
                $display("FAIL outputs cyc=%0d act=%h exp=%h", t, act, exp_q[t]);
            end
            cnt_es += int'(eng_start_o);
            cnt_dn += int'(done_o);
            while (mi < mk_q.size() && mk_q[mi].cyc == t + 1) begin
                n_vec++;
                if (cnt_es != mk_q[mi].es) begin
                    n_mis++;
                    $display("FAIL eng_start_count cyc=%0d act=%0d exp=%0d", t, cnt_es, mk_q[mi].es);
                end
                n_vec++;
                if (cnt_dn != mk_q[mi].dn) begin
                    n_mis++;
                    $display("FAIL done_count cyc=%0d act=%0d exp=%0d", t, cnt_dn, mk_q[mi].dn);
                end
                if (mk_q[mi].ln >= 0) begin
                    n_vec++;
                    if (int'(eng_len_o) != mk_q[mi].ln) begin
                        n_mis++;
                        $display("FAIL eng_len cyc=%0d act=%0d exp=%0d", t, eng_len_o, mk_q[mi].ln);
                    end
                end
                mi++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
